credit_link: RTL

- Parametrised successor to the fixed-delay inter-node link model. Models one direction of a board-to-board link between two router ports.
- Carries flits over a DELAY-stage forward pipe into a receive FIFO of DEPTH entries. Consumer pops return credits over a DELAY-stage return pipe.
- Transmitter backpressure is credit-based, so flits are never dropped, unlike the free-running valid-only link.
- Instantiated once per output port of a node, between the router out_* port and the neighbour's in_* port.

---
 rtl/credit_link.sv | 123 ++++++++++++
 1 files changed

// File: rtl/credit_link.sv
// One direction of a board-to-board link: flits cross a DELAY-stage forward pipe into a
// show-ahead receive FIFO, and consumer pops return credits over a DELAY-stage return pipe.
module credit_link #(
  parameter int FLIT_SIZE = 82,
  parameter int DELAY     = 6,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] tx_par_data,
  input  logic                 tx_par_data_valid,
  output logic                 tx_ready,
  output logic [FLIT_SIZE-1:0] rx_par_data,
  output logic                 rx_par_data_valid,
  input  logic                 rx_ready,
  output logic [CNT_W-1:0]     credit_count,
  output logic [CNT_W-1:0]     rx_fill,
  output logic                 overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0]     credit_reg, credit_next;
  logic [CNT_W-1:0]     fill_reg, fill_next;
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic                 overflow_reg;
  logic [DELAY-1:0]     fwd_valid_reg;
  logic [FLIT_SIZE-1:0] fwd_data_reg [DELAY];
  logic [DELAY-1:0]     ret_reg;
  logic [FLIT_SIZE-1:0] mem [DEPTH];

  logic accept, pop, wr_req, fifo_full, fifo_write, ret_tok;

  assign tx_ready          = (credit_reg != '0) && rst;
  assign accept            = tx_par_data_valid && tx_ready;
  assign rx_par_data_valid = (fill_reg != '0);
  assign pop               = rx_par_data_valid && rx_ready;
  assign wr_req            = fwd_valid_reg[DELAY-1];
  assign fifo_full         = (fill_reg == FULL_CNT);
  // A pop on the same edge frees the slot, so a write into a full FIFO is still legal then.
  assign fifo_write        = wr_req && (!fifo_full || pop);
  assign ret_tok           = ret_reg[DELAY-1];

  assign credit_count = credit_reg;
  assign rx_fill      = fill_reg;
  assign overflow     = overflow_reg;
  assign rx_par_data  = rx_par_data_valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_valid_reg[0] <= 1'b0;
      fwd_data_reg[0]  <= '0;
      ret_reg[0]       <= 1'b0;
    end else begin
      fwd_valid_reg[0] <= accept;
      fwd_data_reg[0]  <= tx_par_data;
      ret_reg[0]       <= pop;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < DELAY; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          fwd_valid_reg[gi] <= 1'b0;
          fwd_data_reg[gi]  <= '0;
          ret_reg[gi]       <= 1'b0;
        end else begin
          fwd_valid_reg[gi] <= fwd_valid_reg[gi-1];
          fwd_data_reg[gi]  <= fwd_data_reg[gi-1];
          ret_reg[gi]       <= ret_reg[gi-1];
        end
      end
    end
  endgenerate

  // Storage carries no reset; the output mux hides stale entries while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (fifo_write) mem[wr_ptr_reg] <= fwd_data_reg[DELAY-1];
  end

  always_comb begin
    credit_next = credit_reg;
    fill_next   = fill_reg;
    case ({accept, ret_tok})
      2'b10:   credit_next = credit_reg - CNT_W'(1);
      2'b01:   credit_next = credit_reg + CNT_W'(1);
      default: credit_next = credit_reg;
    endcase
    case ({fifo_write, pop})
      2'b10:   fill_next = fill_reg + CNT_W'(1);
      2'b01:   fill_next = fill_reg - CNT_W'(1);
      default: fill_next = fill_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_reg   <= FULL_CNT;
      fill_reg     <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      credit_reg <= credit_next;
      fill_reg   <= fill_next;
      if (fifo_write) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop)        rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
      if (wr_req && fifo_full && !pop) overflow_reg <= 1'b1;
    end
  end

  // Both conditions are impossible while the credit loop is intact.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                  !(wr_req && fifo_full && !pop));
  a_credit_max:  assert property (@(posedge clk) disable iff (!rst)
                                  credit_reg <= FULL_CNT);

endmodule
